triangle_channel: RTL and testbench

Parametrised successor to the APU triangle generator, used in the APU channel mixer path.
- Timer, power-of-two step sequencer, linear counter with reload flag, and length counter on its own half-frame strobe.
- Adds a sawtooth mode, channel-enable gating, a length-active status bit and optional ultrasonic muting.
- Reset is synchronous; register interface is unchanged from the existing channels.

---
 rtl/apu_pkg.sv | 17 +
 rtl/triangle_channel_if.sv | 27 ++
 rtl/apu_length_counter.sv | 33 +++
 rtl/triangle_channel.sv | 94 +++++++++
 tb/tb_triangle_channel.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/apu_pkg.sv
// Shared constants for the APU channel family: length lookup table and wave-mode codes.
// Latency: none (constants only).
// Backpressure: not applicable.
package apu_pkg;

   // Length counter load values, indexed by the 5-bit length select field of $400B/$4003/...
   localparam logic [7:0] LENGTH_TABLE [32] = '{
      8'h0A, 8'hFE, 8'h14, 8'h02, 8'h28, 8'h04, 8'h50, 8'h06,
      8'hA0, 8'h08, 8'h3C, 8'h0A, 8'h0E, 8'h0C, 8'h1A, 8'h0E,
      8'h0C, 8'h10, 8'h18, 8'h12, 8'h30, 8'h14, 8'h60, 8'h16,
      8'hC0, 8'h18, 8'h48, 8'h1A, 8'h10, 8'h1C, 8'h20, 8'h1E
   };

   localparam logic WAVE_TRI = 1'b0;
   localparam logic WAVE_SAW = 1'b1;

endpackage

// File: rtl/triangle_channel_if.sv
// Register-side bus of the triangle channel: CPU register images in, DAC code and status out.
// Latency: none (wiring only).
// Backpressure: none; register events are single-cycle pulses consumed when seen.
interface triangle_channel_if #(
   parameter int OUT_W = 4
);
   logic [7:0]       reg_4008;
   logic [7:0]       reg_400A;
   logic [7:0]       reg_400B;
   logic             reg_event;
   logic             channel_enable;
   logic             wave_mode;
   logic [OUT_W-1:0] tri_out;
   logic             length_active;

   // Register/CPU side
   modport master (
      output reg_4008, reg_400A, reg_400B, reg_event, channel_enable, wave_mode,
      input  tri_out, length_active
   );

   // Channel side
   modport slave (
      input  reg_4008, reg_400A, reg_400B, reg_event, channel_enable, wave_mode,
      output tri_out, length_active
   );
endinterface

// File: rtl/apu_length_counter.sv
// Length counter shared by APU channels: table load, disable clear, halt, half-frame decrement.
// Latency: count updates one clk after load/strobe; active is combinational from count.
// Backpressure: none; load and strobes take effect on the clk they are seen.
module apu_length_counter
   import apu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable_120hz,
   input  logic       channel_enable,
   input  logic       load,
   input  logic       halt,
   input  logic [4:0] select,
   output logic       active,
   output logic [7:0] count
);

   // Disable clears outright; a load beats a coincident decrement; decrement saturates at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (!channel_enable) begin
         count <= 8'd0;
      end else if (load) begin
         count <= LENGTH_TABLE[select];
      end else if (enable_120hz && !halt && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign active = (count != 8'd0);

endmodule

// File: rtl/triangle_channel.sv
// APU triangle/sawtooth channel: timer, step sequencer, linear counter and length counter gating.
// Latency: tri_out is registered one clk after the sequencer value it encodes.
// Backpressure: none; strobes and register events are consumed on the clk they arrive.
module triangle_channel
   import apu_pkg::*;
#(
   parameter int TIMER_W         = 11,
   parameter int SEQ_W           = 5,
   parameter bit ULTRASONIC_MUTE = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable_240hz,
   input  logic               enable_120hz,
   triangle_channel_if.slave  bus
);

   localparam int OUT_W = SEQ_W - 1;
   localparam logic [OUT_W-1:0] MID_CODE = {1'b1, {(OUT_W-1){1'b0}}};

   logic [TIMER_W-1:0] period;
   logic [TIMER_W-1:0] timer;
   logic [SEQ_W-1:0]   seq;
   logic [6:0]         linear_counter;
   logic               reload_flag;
   logic [7:0]         length_count;
   logic               tick;
   logic               mute;
   logic               seq_adv;
   logic [OUT_W-1:0]   out_next;

   assign period  = {bus.reg_400B[TIMER_W-9:0], bus.reg_400A};
   assign tick    = (timer == '0);
   assign mute    = ULTRASONIC_MUTE && (period < TIMER_W'(2));
   assign seq_adv = tick && (linear_counter != 7'd0) && (length_count != 8'd0) && !mute;

   // Timer: reload from the current period on underflow, so period writes land at the next reload.
   always_ff @(posedge clk) begin
      if (!rst_n)    timer <= '0;
      else if (tick) timer <= period;
      else           timer <= timer - 1'b1;
   end

   // Sequencer: step only while every gate is open; otherwise hold so the output freezes.
   always_ff @(posedge clk) begin
      if (!rst_n)       seq <= '0;
      else if (seq_adv) seq <= seq + 1'b1;
   end

   // Output code: mid-scale when muted, folded ramp for triangle, halved ramp for sawtooth.
   always_comb begin
      out_next = seq[SEQ_W-1:1];
      if (mute)
         out_next = MID_CODE;
      else if (bus.wave_mode == WAVE_TRI)
         out_next = seq[SEQ_W-1] ? seq[OUT_W-1:0] : ~seq[OUT_W-1:0];
   end

   // Output register towards the mixer.
   always_ff @(posedge clk) begin
      if (!rst_n) bus.tri_out <= '0;
      else        bus.tri_out <= out_next;
   end

   // Linear counter: quarter-frame reload while the flag is up, else count down to 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         linear_counter <= 7'd0;
      end else if (enable_240hz) begin
         if (reload_flag)                 linear_counter <= bus.reg_4008[6:0];
         else if (linear_counter != 7'd0) linear_counter <= linear_counter - 7'd1;
      end
   end

   // Reload flag: a $400B write sets it and wins over the quarter-frame clear.
   always_ff @(posedge clk) begin
      if (!rst_n)                               reload_flag <= 1'b0;
      else if (bus.reg_event)                   reload_flag <= 1'b1;
      else if (enable_240hz && !bus.reg_4008[7]) reload_flag <= 1'b0;
   end

   apu_length_counter u_length (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable_120hz   (enable_120hz),
      .channel_enable (bus.channel_enable),
      .load           (bus.reg_event),
      .halt           (bus.reg_4008[7]),
      .select         (bus.reg_400B[7:3]),
      .active         (bus.length_active),
      .count          (length_count)
   );

endmodule

// File: tb/tb_triangle_channel.sv
// Self-checking bench for triangle_channel: cycle model feeds a scoreboard queue, plus directed checks.
// Latency: expected values are popped and compared #1 after each clk edge.
// Backpressure: not applicable.
module tb_triangle_channel;

   logic clk = 1'b0;
   logic rst_n;
   logic en240;
   logic en120;

   int checks   = 0;
   int failures = 0;

   triangle_channel_if #(.OUT_W(4)) bus ();

   triangle_channel dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_240hz (en240),
      .enable_120hz (en120),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // Length table written out from the channel description.
   int len_tab [32] = '{
      'h0A, 'hFE, 'h14, 'h02, 'h28, 'h04, 'h50, 'h06,
      'hA0, 'h08, 'h3C, 'h0A, 'h0E, 'h0C, 'h1A, 'h0E,
      'h0C, 'h10, 'h18, 'h12, 'h30, 'h14, 'h60, 'h16,
      'hC0, 'h18, 'h48, 'h1A, 'h10, 'h1C, 'h20, 'h1E
   };

   typedef struct {
      int out;
      int act;
   } exp_t;

   exp_t sb [$];

   // Reference state, integer arithmetic
   int m_timer = 0, m_seq = 0, m_lin = 0, m_len = 0, m_flag = 0, m_out = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clk edge using the inputs currently driven.
   task automatic model_step();
      int period, nt, ns, nl, nf, nlen, no;
      bit mute, tick, ctrl;
      if (!rst_n) begin
         m_timer = 0; m_seq = 0; m_lin = 0; m_len = 0; m_flag = 0; m_out = 0;
      end else begin
         period = (int'(bus.reg_400B) % 8) * 256 + int'(bus.reg_400A);
         mute   = (period < 2);
         tick   = (m_timer == 0);
         ctrl   = (int'(bus.reg_4008) >= 128);
         if (mute)                no = 8;
         else if (bus.wave_mode)  no = m_seq / 2;
         else if (m_seq < 16)     no = 15 - m_seq;
         else                     no = m_seq - 16;
         ns = (tick && m_lin != 0 && m_len != 0 && !mute) ? (m_seq + 1) % 32 : m_seq;
         nt = tick ? period : m_timer - 1;
         nl = m_lin;
         if (en240) begin
            if (m_flag != 0)     nl = int'(bus.reg_4008) % 128;
            else if (m_lin != 0) nl = m_lin - 1;
         end
         nf = m_flag;
         if (en240 && !ctrl) nf = 0;
         if (bus.reg_event)  nf = 1;
         nlen = m_len;
         if (!bus.channel_enable)                   nlen = 0;
         else if (bus.reg_event)                    nlen = len_tab[int'(bus.reg_400B) / 8];
         else if (en120 && !ctrl && m_len != 0)     nlen = m_len - 1;
         m_timer = nt; m_seq = ns; m_lin = nl; m_flag = nf; m_len = nlen; m_out = no;
      end
   endtask

   // One clk: drive strobes, push expectation, then pop and compare after the edge.
   task automatic step(input logic s240, input logic s120, input logic sev);
      exp_t e;
      @(negedge clk);
      en240 = s240;
      en120 = s120;
      bus.reg_event = sev;
      model_step();
      e.out = m_out;
      e.act = (m_len != 0) ? 1 : 0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("tri_out", 8'(bus.tri_out), 8'(e.out));
      chk("length_active", 8'(bus.length_active), 8'(e.act));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   logic [3:0] held;

   initial begin
      rst_n = 1'b0;
      en240 = 1'b0;
      en120 = 1'b0;
      bus.reg_event      = 1'b0;
      bus.channel_enable = 1'b1;
      bus.wave_mode      = 1'b0;
      bus.reg_4008       = 8'h7F;
      bus.reg_400A       = 8'h03;
      bus.reg_400B       = 8'h08;   // select 1 -> FE, period high 0

      // Reset state
      idle(2);
      chk("reset_tri_out", 8'(bus.tri_out), 8'h00);
      chk("reset_length_active", 8'(bus.length_active), 8'h00);

      // Test 1: triangle walk, period 3
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      chk("first_code_after_reset", 8'(bus.tri_out), 8'h0F);
      step(1'b1, 1'b0, 1'b0);
      idle(140);

      // Test 2: sawtooth
      bus.wave_mode = 1'b1;
      idle(140);

      // Test 3: linear counter runs out, output freezes
      bus.wave_mode = 1'b0;
      bus.reg_4008  = 8'h05;
      step(1'b0, 1'b0, 1'b1);
      for (int q = 0; q < 6; q++) begin
         step(1'b1, 1'b0, 1'b0);
         idle(9);
      end
      held = bus.tri_out;
      idle(30);
      chk("linear_zero_frozen", 8'(bus.tri_out), 8'(held));

      // Test 4a: length 02, control 0, two half-frame strobes
      bus.reg_4008 = 8'h7F;
      bus.reg_400B = 8'h18;          // select 3 -> 02
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      idle(10);
      step(1'b1, 1'b1, 1'b0);
      idle(5);
      chk("length_after_one_strobe", 8'(bus.length_active), 8'h01);
      step(1'b1, 1'b1, 1'b0);
      chk("length_after_two_strobes", 8'(bus.length_active), 8'h00);
      held = bus.tri_out;
      idle(20);
      chk("length_zero_frozen", 8'(bus.tri_out), 8'(held));

      // Test 4b: control 1 halts the length counter
      bus.reg_4008 = 8'hFF;
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      idle(3);
      step(1'b1, 1'b1, 1'b0);
      idle(3);
      chk("length_halted", 8'(bus.length_active), 8'h01);

      // Test 5: channel disable while length = 20
      bus.reg_4008 = 8'h7F;
      bus.reg_400B = 8'hF0;          // select 30 -> 20
      step(1'b0, 1'b0, 1'b1);
      idle(3);
      chk("length_loaded_20", 8'(bus.length_active), 8'h01);
      bus.channel_enable = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      chk("disable_clears_length", 8'(bus.length_active), 8'h00);
      step(1'b0, 1'b0, 1'b1);
      idle(2);
      chk("disabled_ignores_load", 8'(bus.length_active), 8'h00);
      bus.channel_enable = 1'b1;

      // Test 6: ultrasonic mute and load beating a coincident decrement
      bus.reg_400A = 8'h01;
      bus.reg_400B = 8'h18;          // select 3 -> 02, period 1
      step(1'b1, 1'b1, 1'b1);
      idle(2);
      step(1'b1, 1'b1, 1'b0);
      idle(2);
      chk("load_beats_decrement", 8'(bus.length_active), 8'h01);
      chk("mute_mid_scale", 8'(bus.tri_out), 8'h08);
      idle(20);
      chk("mute_held", 8'(bus.tri_out), 8'h08);

      // Mid-operation reset
      bus.reg_400A = 8'h03;
      step(1'b0, 1'b0, 1'b1);
      idle(10);
      rst_n = 1'b0;
      step(1'b1, 1'b1, 1'b1);
      chk("midop_reset_tri_out", 8'(bus.tri_out), 8'h00);
      chk("midop_reset_length", 8'(bus.length_active), 8'h00);
      rst_n = 1'b1;
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
